// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Two-stage pipelined integer execute stage placed between decode/operand
//   fetch and writeback.
//     S1 (operand prep): captures A, op and B'. For SUB/SLT/SLTU, B' is ~B and
//                        the carry-in is 1, so S2 needs only one adder.
//     S2 (compute):      forms A + B' + cin, selects the result for the op and
//                        registers the result together with its flags.
//   Both ends use valid/ready. in_ready is combinational from out_ready, and
//   there is no skid buffer. Throughput is one op per cycle while the
//   downstream keeps out_ready high, and latency is two cycles from accept to
//   out_valid.
//
// Ports
//   clk        in   1  clock; all state changes on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   flush      in   1  synchronous kill of both stages
//   in_valid   in   1  upstream presents op/a/b
//   in_ready   out  1  accept occurs when in_valid & in_ready & !flush
//   op         in   3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                      101 NOT A, 110 SLT, 111 SLTU
//   a, b       in   N  operands
//   out_valid  out  1  result and flags are valid
//   out_ready  in   1  downstream accepts when out_valid & out_ready
//   result     out  N  ALU result
//   zero       out  1  result == 0
//   negative   out  1  result[N-1]
//   carry      out  1  adder carry-out for ADD/SUB (SUB: 1 = no borrow), else 0
//   overflow   out  1  signed overflow for ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    // S1 registers
    logic         s1_valid;
    logic [2:0]   s1_op;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;      // b' : ~b for subtract-style ops, b otherwise
    logic         s1_cin;

    // S2 registers
    logic         s2_valid;
    logic [N-1:0] s2_result;
    logic         s2_zero;
    logic         s2_negative;
    logic         s2_carry;
    logic         s2_overflow;

    logic         s1_adv;
    logic         s2_adv;
    logic         in_fire;
    logic         s2_load;
    logic         sub_style;

    // S2 combinational compute, fed only by the S1 registers
    logic [N:0]   sum_ext;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         is_arith;
    logic [N-1:0] alu_res;

    // -------------------------------------------------------------------------
    // Handshake / advance
    // -------------------------------------------------------------------------
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // flush drops an input presented in the same cycle, even when in_ready=1.
    assign in_fire  = in_valid && s1_adv && !flush;
    assign s2_load  = s1_valid && s2_adv && !flush;

    assign sub_style = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);

    // -------------------------------------------------------------------------
    // S1: operand prep
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid;
            end

            if (in_fire) begin
                s1_op  <= op;
                s1_a   <= a;
                s1_b   <= sub_style ? ~b : b;
                s1_cin <= sub_style;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2 compute (combinational part)
    // -------------------------------------------------------------------------
    assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b} + {{N{1'b0}}, s1_cin};
    assign sum      = sum_ext[N-1:0];
    assign c_out    = sum_ext[N];

    // Signed overflow of a + b': the operands agree in sign and the sum does not.
    assign ovf      = (s1_a[N-1] == s1_b[N-1]) && (sum[N-1] != s1_a[N-1]);

    assign is_arith = (s1_op == OP_ADD) || (s1_op == OP_SUB);

    always_comb begin
        alu_res = '0;
        case (s1_op)
            OP_ADD,
            OP_SUB:  alu_res = sum;
            // For logic ops S1 keeps b' = b, so s1_b is the original operand.
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_NOT:  alu_res = ~s1_a;
            // A < B (signed) when the true sign of A - B is negative.
            OP_SLT:  alu_res = {{(N-1){1'b0}}, sum[N-1] ^ ovf};
            // A < B (unsigned) when A - B borrows, i.e. there is no carry out.
            OP_SLTU: alu_res = {{(N-1){1'b0}}, ~c_out};
            default: alu_res = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // S2 registers. These are loaded only on advance, so a stalled output
    // holds bit-for-bit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_result   <= '0;
            s2_zero     <= 1'b0;
            s2_negative <= 1'b0;
            s2_carry    <= 1'b0;
            s2_overflow <= 1'b0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end

            if (s2_load) begin
                s2_result   <= alu_res;
                s2_zero     <= (alu_res == '0);
                s2_negative <= alu_res[N-1];
                s2_carry    <= is_arith & c_out;
                s2_overflow <= is_arith & ovf;
            end
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign zero      = s2_zero;
    assign negative  = s2_negative;
    assign carry     = s2_carry;
    assign overflow  = s2_overflow;

endmodule
